fft_output_reorder_buffer: RTL and testbench

- Downstream stage of the 8-point FFT processor.
- Captures the processor's serial complex results (r, i), which arrive in bit-reversed index order, into a ping-pong register buffer.
- Streams each frame out in natural order X[0]..X[N-1] over a valid/ready handshake.
- Decouples FFT compute from the consumer: one frame can be read while the next is being written.

---
 rtl/fft_output_reorder_buffer.sv | 103 ++++++++++
 tb/tb_fft_output_reorder_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_reorder_buffer.sv
// Ping-pong reorder buffer: bit-reversed FFT results in, natural-order X[0]..X[N-1] out.
// Latency: out_valid rises the cycle after the edge that accepts a frame's N-th sample.
// Backpressure: in_ready drops while both banks hold frames (extra input sets sticky ovf); outputs hold while out_ready is low.
// Optional FFT_REORDER_MAG_EN adds out_mag = out_r^2 + out_i^2.
module fft_output_reorder_buffer #(
    parameter int W      = 16,
    parameter int LOG2N  = 3,
    parameter int BITREV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_r,
    input  logic [W-1:0]     in_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_r,
    output logic [W-1:0]     out_i,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last,
`ifdef FFT_REORDER_MAG_EN
    output logic [2*W:0]     out_mag,
`endif
    output logic             ovf
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = '1;

    logic [2*W-1:0]   mem [2][N];
    logic [1:0]       full;
    logic             wbank, rbank;
    logic [LOG2N-1:0] wcnt, rcnt, waddr;
    logic             wr_acc, rd_acc;
    logic [2*W-1:0]   rd_word;

    always_comb begin
        waddr = wcnt;
        if (BITREV != 0) begin
            for (int b = 0; b < LOG2N; b++) begin
                waddr[b] = wcnt[LOG2N-1-b];
            end
        end
    end

    assign in_ready  = ~full[wbank];
    assign wr_acc    = in_valid & in_ready;
    assign out_valid = full[rbank];
    assign rd_acc    = out_valid & out_ready;

    // Storage is deliberately not reset; full[] gates every read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wbank][waddr] <= {in_r, in_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 2'b00;
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
            rcnt  <= '0;
            ovf   <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                ovf <= 1'b1;
            end
            // Write completion targets an empty bank and read completion a full one,
            // so the two updates to full[] never touch the same bit.
            if (wr_acc) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == LAST) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end
            end
            if (rd_acc) begin
                rcnt <= rcnt + 1'b1;
                if (rcnt == LAST) begin
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                end
            end
        end
    end

    assign rd_word  = mem[rbank][rcnt];
    assign out_r    = out_valid ? rd_word[2*W-1:W] : '0;
    assign out_i    = out_valid ? rd_word[W-1:0]   : '0;
    assign out_idx  = rcnt;
    assign out_last = out_valid & (rcnt == LAST);

`ifdef FFT_REORDER_MAG_EN
    logic signed [2*W-1:0] sq_r, sq_i;

    assign sq_r    = $signed(out_r) * $signed(out_r);
    assign sq_i    = $signed(out_i) * $signed(out_i);
    assign out_mag = {1'b0, sq_r} + {1'b0, sq_i};
`endif

endmodule

// File: tb/tb_fft_output_reorder_buffer.sv
// Bench for fft_output_reorder_buffer: directed and random traffic against a frame-queue reference model.
module tb_fft_output_reorder_buffer;
    localparam int W     = 16;
    localparam int LOG2N = 3;
    localparam int N     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [W-1:0]     in_r, in_i;
    logic             out_valid, out_ready;
    logic [W-1:0]     out_r, out_i;
    logic [LOG2N-1:0] out_idx;
    logic             out_last;
    logic             ovf;
`ifdef FFT_REORDER_MAG_EN
    logic [2*W:0]     out_mag;
`endif

    fft_output_reorder_buffer #(.W(W), .LOG2N(LOG2N), .BITREV(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_idx   (out_idx),
        .out_last  (out_last),
`ifdef FFT_REORDER_MAG_EN
        .out_mag   (out_mag),
`endif
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] i;
    } smp_t;

    smp_t part[$];   // samples of the frame currently being written, arrival order
    smp_t outq[$];   // natural-order samples of complete frames not yet consumed
    logic m_ovf;
    int   checks = 0;
    int   errors = 0;

    function automatic int bitrev(input int k);
        int res = 0;
        int v   = k;
        for (int b = 0; b < LOG2N; b++) begin
            res = res * 2 + v % 2;
            v   = v / 2;
        end
        return res;
    endfunction

    // A bank stays occupied until the last sample of its frame is consumed.
    function automatic logic model_ready();
        return ((outq.size() + N - 1) / N) < 2;
    endfunction

    task automatic check_now();
        logic        e_vld;
        int          idx;
        logic [2:0]  e_idx;
        logic [6:0]  e_ctl, a_ctl;
        logic [31:0] e_dat, a_dat;
        e_vld = (outq.size() > 0);
        idx   = e_vld ? (N - outq.size() % N) % N : 0;
        e_idx = idx[2:0];
        e_ctl = {model_ready(), e_vld, e_idx, e_vld && (idx == N - 1), m_ovf};
        a_ctl = {in_ready, out_valid, out_idx, out_last, ovf};
        e_dat = e_vld ? {outq[0].r, outq[0].i} : 32'h0;
        a_dat = {out_r, out_i};
        checks++;
        assert (a_ctl === e_ctl) else begin
            errors++;
            $error("FAIL ctl {rdy,vld,idx,last,ovf} observed %b expected %b", a_ctl, e_ctl);
        end
        checks++;
        assert (a_dat === e_dat) else begin
            errors++;
            $error("FAIL data {r,i} observed %h expected %h", a_dat, e_dat);
        end
`ifdef FFT_REORDER_MAG_EN
        begin
            longint er, ei;
            logic [32:0] e_mag;
            er    = e_vld ? longint'($signed(outq[0].r)) : 0;
            ei    = e_vld ? longint'($signed(outq[0].i)) : 0;
            e_mag = 33'(er * er + ei * ei);
            checks++;
            assert (out_mag === e_mag) else begin
                errors++;
                $error("FAIL mag observed %0d expected %0d", out_mag, e_mag);
            end
        end
`endif
    endtask

    // One clock: drive at negedge, check, then advance the model across the posedge.
    task automatic cyc(input logic iv, input logic [W-1:0] r, input logic [W-1:0] ii, input logic ordy);
        logic rdy, vld;
        in_valid  = iv;
        in_r      = r;
        in_i      = ii;
        out_ready = ordy;
        check_now();
        rdy = model_ready();
        vld = (outq.size() > 0);
        @(posedge clk);
        if (vld && ordy) void'(outq.pop_front());
        if (iv && !rdy) m_ovf = 1'b1;
        if (iv && rdy) begin
            part.push_back('{r, ii});
            if (part.size() == N) begin
                for (int k = 0; k < N; k++) outq.push_back(part[bitrev(k)]);
                part.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_r      = '0;
        in_i      = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        part.delete();
        outq.delete();
        m_ovf = 1'b0;
    endtask

    task automatic rand_frames(input int nf, input int mode);
        logic [31:0] d;
        for (int c = 0; c < nf * N; c++) begin
            d = $urandom;
            case (mode)
                0:       cyc(1'b1, d[31:16], d[15:0], 1'b0);
                1:       cyc(1'b1, d[31:16], d[15:0], 1'b1);
                default: cyc(1'b1, d[31:16], d[15:0], c[0]);
            endcase
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int c = 0; c < n; c++) cyc(1'b0, '0, '0, ordy);
    endtask

    initial begin
        logic [31:0] d;
        @(negedge clk);
        do_reset();

        // reset state while idle
        idle(3, 1'b0);

        // ramp frame, bit-reversed arrival 0..7 / 100..107
        for (int k = 0; k < N; k++) cyc(1'b1, W'(k), W'(100 + k), 1'b1);
        idle(10, 1'b1);

        // three frames with consumer stalled: third overruns
        rand_frames(3, 0);
        checks++;
        assert (ovf === 1'b1) else begin
            errors++;
            $error("FAIL ovf_sticky observed %b expected 1", ovf);
        end
        idle(20, 1'b1);

        // ping-pong streaming, four frames back-to-back
        do_reset();
        rand_frames(4, 1);
        idle(10, 1'b1);

        // consumer toggling out_ready every cycle
        rand_frames(2, 2);
        idle(24, 1'b1);

        // fully random traffic
        do_reset();
        for (int c = 0; c < 300; c++) begin
            d = $urandom;
            cyc(d[0] | d[1], d[31:16], {d[15:2], 2'b01}, d[2] | d[3]);
        end
        idle(24, 1'b1);

        // reset mid-frame, then a clean frame
        for (int k = 0; k < 5; k++) cyc(1'b1, W'(50 + k), W'(60 + k), 1'b1);
        do_reset();
        idle(4, 1'b1);
        for (int k = 0; k < N; k++) cyc(1'b1, W'(200 + k), W'(300 + k), 1'b1);
        idle(10, 1'b1);

        // magnitude corner samples
        cyc(1'b1, 16'sd3, -16'sd4, 1'b1);
        cyc(1'b1, 16'h8000, 16'h8000, 1'b1);
        for (int k = 2; k < N; k++) begin
            d = $urandom;
            cyc(1'b1, d[31:16], d[15:0], 1'b1);
        end
        idle(10, 1'b0);
        idle(10, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
